// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: binary-to-BCD converter plus 4-digit multiplexed 7-segment scanner
module seg7_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] num,
  input  logic        num_valid,
  output logic        num_ready,
  input  logic        disp_en,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        ovf,
  output logic        done
);
  localparam int PW = $clog2(SCAN_DIV);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t          state_q, state_d;
  logic [13:0]     bin_q, bin_d, lat_q, lat_d;
  logic [15:0]     bcd_q, bcd_d, adj;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0][3:0] dig_q, dig_d;
  logic            ovf_q, ovf_d, done_q, done_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [1:0]      idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d, nz;
  logic            wrap, blank;
  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: enc = 7'b1000000;
      4'd1: enc = 7'b1111001;
      4'd2: enc = 7'b0100100;
      4'd3: enc = 7'b0110000;
      4'd4: enc = 7'b0011001;
      4'd5: enc = 7'b0010010;
      4'd6: enc = 7'b0000010;
      4'd7: enc = 7'b1111000;
      4'd8: enc = 7'b0000000;
      4'd9: enc = 7'b0010000;
      default: enc = 7'b1111111;
    endcase
  endfunction
  // add-3 correction of every BCD nibble ahead of the next shift
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++)
      adj[i*4+:4] = bcd_q[i*4+:4] >= 4'd5 ? bcd_q[i*4+:4] + 4'd3 : bcd_q[i*4+:4];
  end
  // conversion FSM: accept, 14 shift-add-3 steps, commit digits
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    lat_d   = lat_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (num_valid) begin
        bin_d   = num;
        lat_d   = num;
        bcd_d   = '0;
        cnt_d   = 4'd13;
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adj[14:0], bin_q, 1'b0};
        cnt_d   = cnt_q - 4'd1;
        state_d = cnt_q == 4'd0 ? COMMIT : SHIFT;
      end
      COMMIT: begin
        dig_d   = bcd_q;
        ovf_d   = lat_q > 14'd9999;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // free-running scan: prescaler, digit index and registered anode/segment drive
  always_comb begin
    wrap = pre_q == PW'(SCAN_DIV - 1);
    pre_d = wrap ? '0 : pre_q + 1'b1;
    idx_d = wrap ? idx_q + 2'd1 : idx_q;
    for (int i = 0; i < 4; i++) nz[i] = dig_q[i] != 4'd0;
    blank = LZ_BLANK && idx_q != 2'd0 && (nz >> idx_q) == 4'd0;
    an_d  = disp_en ? ~(4'b0001 << idx_q) : 4'b1111;
    seg_d = !disp_en ? 7'b1111111 : ovf_q ? 7'b0111111 : blank ? 7'b1111111 : enc(dig_q[idx_q]);
  end
  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      lat_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
      seg_q   <= 7'b1111111;
      an_q    <= 4'b1111;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      lat_q   <= lat_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end
  assign num_ready = state_q == IDLE;
  assign seg       = seg_q;
  assign an        = an_q;
  assign ovf       = ovf_q;
  assign done      = done_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: randomized check of seg7_scan_ctrl against a value-level display model
module tb_seg7_scan_ctrl;
  localparam int S = 4;
  logic clk = 1'b0, rst_n = 1'b0, num_valid = 1'b0, disp_en = 1'b1;
  logic [13:0] num = '0;
  logic r1, r0, o1, o0, d1, d0;
  logic [6:0] s1, s0;
  logic [3:0] a1, a0;
  int checks = 0, errors = 0;
  seg7_scan_ctrl #(.SCAN_DIV(S), .LZ_BLANK(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .num(num), .num_valid(num_valid),
    .num_ready(r1), .disp_en(disp_en), .seg(s1), .an(a1), .ovf(o1), .done(d1));
  seg7_scan_ctrl #(.SCAN_DIV(S), .LZ_BLANK(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .num(num), .num_valid(num_valid),
    .num_ready(r0), .disp_en(disp_en), .seg(s0), .an(a0), .ovf(o0), .done(d0));
  always #5 clk = ~clk;
  // model state: committed value, pending conversion, scan time since reset
  bit armed = 0, busy = 0, movf = 0, mdone = 0;
  int val = 0, lat = 0, rem = 0, k = 0;
  logic [3:0] e_an = 4'hf;
  logic [6:0] e_s1 = 7'h7f, e_s0 = 7'h7f;
  function automatic logic [6:0] mseg(int v, bit o, int d, bit lz);
    logic [6:0] t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int p = 1;
    for (int i = 0; i < d; i++) p *= 10;
    if (o) return 7'h3f;
    if (lz && d > 0 && v < p) return 7'h7f;
    return t[(v / p) % 10];
  endfunction
  always @(posedge clk) begin
    if (!rst_n) begin
      armed = 1; busy = 0; movf = 0; mdone = 0; val = 0; rem = 0; k = 0;
      e_an = 4'hf; e_s1 = 7'h7f; e_s0 = 7'h7f;
    end else begin
      e_an = disp_en ? ~(4'b0001 << ((k / S) % 4)) : 4'hf;
      e_s1 = disp_en ? mseg(val, movf, (k / S) % 4, 1) : 7'h7f;
      e_s0 = disp_en ? mseg(val, movf, (k / S) % 4, 0) : 7'h7f;
      k = (k + 1) % (4 * S);
      mdone = 0;
      if (busy) begin
        rem--;
        if (rem == 0) begin val = lat; movf = lat > 9999; mdone = 1; busy = 0; end
      end else if (num_valid) begin
        busy = 1; rem = 15; lat = num;
      end
    end
  end
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (armed) begin
    chk("an1", 16'(a1), 16'(e_an));
    chk("an0", 16'(a0), 16'(e_an));
    chk("seg1", 16'(s1), 16'(e_s1));
    chk("seg0", 16'(s0), 16'(e_s0));
    chk("ready", {r1, r0}, {2{!busy}});
    chk("done", {d1, d0}, {2{mdone}});
    chk("ovf", {o1, o0}, {2{movf}});
  end
  task automatic see(input bit lz, input logic [3:0] av, input logic [6:0] sv, input string n);
    bit hit = 0;
    for (int i = 0; i < 4 * S + 4 && !hit; i++) begin
      @(negedge clk);
      hit = (lz ? a1 : a0) == av;
    end
    chk({n, "_found"}, 16'(hit), 16'd1);
    if (hit) chk(n, 16'(lz ? s1 : s0), 16'(sv));
  endtask
  task automatic conv(input int v, input bit extra, input int nxt);
    int low = 0, dn = 0, dc = 0;
    @(negedge clk); num = 14'(v); num_valid = 1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      num_valid = extra && (c == 3 || c == 10 || c == 16);
      if (c == 16 && extra) num = 14'(nxt);
      if (c <= 16 && !r1) low++;
      if (c <= 16 && d1) begin dn++; dc = c; end
      if (c == 17 && extra) chk("accept_e16", 16'(r1), 16'd0);
    end
    num_valid = 0;
    chk("ready_low_cycles", 16'(low), 16'd15);
    chk("done_count", 16'(dn), 16'd1);
    chk("done_cycle", 16'(dc), 16'd16);
    repeat (20) @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_an", 16'(a1), 16'hf);
    chk("rst_seg", 16'(s1), 16'h7f);
    chk("rst_ready", 16'(r1), 16'd1);
    rst_n = 1;
    repeat (20) @(negedge clk);
    see(1, 4'b1110, 7'b1000000, "idle_units");
    see(1, 4'b0111, 7'b1111111, "idle_thou");
    conv(1234, 0, 0);
    see(1, 4'b1110, 7'b0011001, "d1234_0");
    see(1, 4'b1101, 7'b0110000, "d1234_1");
    see(1, 4'b1011, 7'b0100100, "d1234_2");
    see(1, 4'b0111, 7'b1111001, "d1234_3");
    conv(1234, 1, 56);
    see(1, 4'b1110, 7'b0000010, "lz56_0");
    see(1, 4'b1101, 7'b0010010, "lz56_1");
    see(1, 4'b1011, 7'b1111111, "lz56_2");
    see(0, 4'b0111, 7'b1000000, "nolz56_3");
    conv(10000, 0, 0);
    chk("ovf_lit", 16'(o1), 16'd1);
    see(1, 4'b1110, 7'b0111111, "ovf_0");
    see(1, 4'b1011, 7'b0111111, "ovf_2");
    conv(9999, 0, 0);
    see(1, 4'b0111, 7'b0010000, "d9999_3");
    @(negedge clk); num = 14'd8765; num_valid = 1;
    @(negedge clk); num_valid = 0;
    repeat (5) @(negedge clk);
    rst_n = 0;
    @(negedge clk); rst_n = 1;
    repeat (25) @(negedge clk);
    see(1, 4'b1110, 7'b1000000, "abort_units");
    see(1, 4'b1101, 7'b1111111, "abort_tens");
    disp_en = 0;
    @(negedge clk); chk("dis_an", 16'(a1), 16'hf);
    repeat (6) @(negedge clk);
    disp_en = 1;
    repeat (4000) begin
      @(negedge clk);
      num_valid = $urandom % 3 == 0;
      case ($urandom % 4)
        0: num = 14'($urandom % 10);
        1: num = 14'($urandom % 100);
        2: num = 14'($urandom % 10000);
        default: num = 14'($urandom % 16384);
      endcase
      disp_en = $urandom % 16 != 0;
      rst_n = $urandom % 500 != 0;
    end
    rst_n = 1; num_valid = 0;
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Sequencing controller for the 4-digit 7-segment display path.
- Accepts a 14-bit binary value over a valid/ready handshake and converts it to BCD with an iterative shift-add-3 engine (no dividers).
- Holds the committed digits and time-multiplexes them onto one shared segment bus with per-digit anode enables.
- Sits between any value producer (counter, sensor) and the board's multiplexed display pins.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays lit (must be >= 2).
- LZ_BLANK, 1, 1 blanks leading zeros (digit 0 is never blanked); 0 shows all digits.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- num  in  14  binary value to display, 0..16383.
- num_valid  in  1  num is valid this cycle.
- num_ready  out  1  controller idle and can accept num.
- disp_en  in  1  0 forces all anodes off; scanning continues internally.
- seg  out  7  {g,f,e,d,c,b,a}, active-low (0 lights a segment).
- an  out  4  digit enables, active-low, one-hot; an[0] is the units digit.
- ovf  out  1  committed value was above 9999.
- done  out  1  one-cycle pulse when a new value is committed.

Behaviour:
- Reset (rst_n=0 at an edge):
  - FSM goes to IDLE; digit registers = 0; ovf=0, done=0.
  - Prescaler = 0, scan index = 0; an=4'b1111, seg=7'b1111111.
  - A reset during conversion aborts it with no commit.
- num_ready = (state==IDLE), combinational from state.
- FSM states: IDLE -> SHIFT -> COMMIT -> IDLE.
- IDLE:
  - On num_valid && num_ready at edge E0: latch num, clear the 16-bit BCD accumulator, load iteration count 13, go to SHIFT.
  - num_valid while not ready is ignored, not queued.
- SHIFT, edges E1..E14:
  - Each nibble >=5 gets +3, then {bcd,bin} shifts left by 1.
  - Count decrements; leave to COMMIT after count 0 (14 shifts total).
- COMMIT, edge E15:
  - Digit registers <= BCD nibbles; ovf <= (latched num > 9999); done <= 1 for the cycle after E15.
  - Return to IDLE, so num_ready is high again after E15.
- Latency: accept at E0, new digits visible on seg from the first scan slot after E15.
- Back-to-back: a new value can be accepted at E16 at the earliest.
- Old digits are displayed unchanged throughout a conversion.
- Scanner (free-running, independent of FSM):
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - At the wrap, the index goes 0->1->2->3->0.
  - an and seg are registered from the current index and digit registers, so they lag the index by one cycle.
- Encoding (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - dash = 0111111, blank = 1111111.
- Blanking (LZ_BLANK=1): digit k>0 is blank if it and all higher digits are 0. A value of 0 displays "   0".
- ovf=1: all four digits show dash regardless of the BCD value. Blanking does not apply.
- disp_en=0: an=4'b1111 and seg=blank on the next edge; the index keeps advancing.
- Index wraps 3->0 with no gap cycle.
- Prescaler is never reset by a commit.

Test Plan:
- Reset, then SCAN_DIV=4, LZ_BLANK=1, no input -> an cycles 1110 (seg 1000000) while 1101/1011/0111 show blank; each slot lasts 4 cycles.
- Send num=1234 with valid -> num_ready low 15 cycles; done pulses once at cycle 16; digits show 4,3,2,1 (0011001, 0110000, 0100100, 1111001) on an[0..3].
- Send num=10000 -> ovf=1, all digits 0111111. Then send 9999 -> ovf=0, all 0010000.
- Send 56 with LZ_BLANK=1 -> units 0000010, tens 0010010, hundreds/thousands blank; same with LZ_BLANK=0 -> hundreds/thousands 1000000.
- Assert valid again at cycles 3 and 10 of a 1234 conversion -> both ignored, done pulses once, value 1234; a valid at E16 is accepted.
- Reset asserted mid-conversion of 8765 -> no done, digits 0, display "   0"; disp_en=0 -> an=1111 next cycle, and the index is unchanged in phase when re-enabled.
